// File: rtl/otter_db_pkg.sv
// ----------------------------------------------------------------------------
// otter_db_pkg
// Shared types and helpers for the push-button debouncer.
//   db_state_t    : per-channel qualification state (2-bit encoding)
//   db_cnt_width  : stability-counter width, never less than one bit
//   db_level      : debounced level implied by a given state
// ----------------------------------------------------------------------------
package otter_db_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HIGH         = 2'b10,
        RELEASE_WAIT = 2'b11
    } db_state_t;

    // $clog2(1) is 0, so a single-cycle qualification still needs one bit.
    function automatic int db_cnt_width(input int count);
        if (count > 1) begin
            return $clog2(count);
        end else begin
            return 1;
        end
    endfunction

    // Level is 1 in both states that belong to the "pressed" side.
    function automatic logic db_level(input db_state_t st);
        logic lvl;
        case (st)
            HIGH:         lvl = 1'b1;
            RELEASE_WAIT: lvl = 1'b1;
            IDLE:         lvl = 1'b0;
            PRESS_WAIT:   lvl = 1'b0;
            default:      lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/db_channel.sv
// ----------------------------------------------------------------------------
// db_channel
// One debounced button: optional two-flop synchroniser, stability counter and
// four-state qualification FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw button bit (1 = pressed)
//   level      : debounced level, registered
//   pulse      : one-cycle pulse on each accepted press, registered
// Macro BTN_DB_SYNC_EN: when defined, btn_in passes through a two-flop
// synchroniser (adds two cycles of latency); when undefined, btn_in is used
// directly and must already be synchronous to clk.
// ----------------------------------------------------------------------------
module db_channel
    import otter_db_pkg::*;
#(
    parameter int DB_COUNT = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic pulse
);

    localparam int              CW        = db_cnt_width(DB_COUNT);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DB_COUNT - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);

    logic            sample_s;
    db_state_t       state_r;
    db_state_t       state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            pulse_next_s;
    logic            level_r;
    logic            pulse_r;

`ifdef BTN_DB_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchroniser bringing the asynchronous pin into clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r;
`else
    assign sample_s = btn_in;
`endif

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            level_r <= db_level(state_next_s);
            pulse_r <= pulse_next_s;
        end
    end

    // Next-state logic: a sample disagreeing with the stable side restarts
    // qualification; the counter saturates at CNT_MAX via the state change.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pulse_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sample_s) begin
                    state_next_s = PRESS_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sample_s) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    state_next_s = HIGH;
                    pulse_next_s = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sample_s) begin
                    state_next_s = RELEASE_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = HIGH;
                end
            end
            RELEASE_WAIT: begin
                // Returning to HIGH from here is a rejected release, not a press.
                if (sample_s) begin
                    state_next_s = HIGH;
                end else if (cnt_r == CNT_MAX) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    assign level = level_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Multi-channel push-button conditioner; each channel is independent.
//   CLK       : system clock, rising edge
//   RST_N     : asynchronous active-low reset
//   BTN_IN    : raw button pins, 1 = pressed
//   BTN_LEVEL : debounced level per channel, registered
//   BTN_PULSE : one-cycle pulse per accepted press, registered
// Macro BTN_DB_SYNC_EN enables the per-channel two-flop synchroniser.
// ----------------------------------------------------------------------------
module button_debouncer
    import otter_db_pkg::*;
#(
    parameter int N_BTN    = 2,
    parameter int DB_COUNT = 500_000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PULSE
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        db_channel #(
            .DB_COUNT (DB_COUNT)
        ) u_ch (
            .clk    (CLK),
            .rst_n  (RST_N),
            .btn_in (BTN_IN[g]),
            .level  (BTN_LEVEL[g]),
            .pulse  (BTN_PULSE[g])
        );
    end

endmodule
